// File: rtl/sa_seq_pkg.sv
// Shared types and default geometry for the systolic tile sequencer.
// Holds the state enum, command mode codes and default strides.
package sa_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_W    = 3'd1,
        S_STREAM    = 3'd2,
        S_DRAIN     = 3'd3,
        S_SAVE      = 3'd4,
        S_WAIT_HASH = 3'd5,
        S_DONE      = 3'd6
    } seq_state_e;

    localparam logic [1:0] MODE_AS = 2'd1;
    localparam logic [1:0] MODE_SA = 2'd2;

    localparam int DEF_TILE     = 4;
    localparam int DEF_N_ROWS   = 1344;
    localparam int DEF_N_BLK    = 4;
    localparam int DEF_A_STRIDE = 21504;
    localparam int DEF_S_STRIDE = 10752;
    localparam int DEF_B_BASE   = 86016;
    localparam int DEF_B_ROW    = 128;
    localparam int DEF_B_BLK    = 64;

    // Counter width for a range of n values; never narrower than 1 bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sa_addr_gen.sv
// Combinational BRAM address generator for the tile sequencer.
// Ports: state_i, is_as_i, t_i, l_i, r_i, blk_i in; addr_hash_o, addr_sp_o out.
module sa_addr_gen
    import sa_seq_pkg::*;
#(
    parameter int TILE     = DEF_TILE,
    parameter int AW       = 32,
    parameter int A_STRIDE = DEF_A_STRIDE,
    parameter int S_STRIDE = DEF_S_STRIDE,
    parameter int S_BLK    = 4 * DEF_S_STRIDE,
    parameter int B_BASE   = DEF_B_BASE,
    parameter int B_ROW    = DEF_B_ROW,
    parameter int B_BLK    = DEF_B_BLK,
    parameter int TW       = 2,
    parameter int LW       = 9,
    parameter int BW       = 2
) (
    input  seq_state_e      state_i,
    input  logic            is_as_i,
    input  logic [TW-1:0]   t_i,
    input  logic [LW-1:0]   l_i,
    input  logic [TW-1:0]   r_i,
    input  logic [BW-1:0]   blk_i,
    output logic [AW-1:0]   addr_hash_o,
    output logic [AW-1:0]   addr_sp_o
);

    localparam logic [AW-1:0] TILE_M1 = AW'(TILE - 1);
    localparam logic [AW-1:0] A_LINE  = AW'(TILE * 16);
    localparam logic [AW-1:0] S_LINE  = AW'(TILE * 8);
    localparam logic [AW-1:0] A_STR   = AW'(A_STRIDE);
    localparam logic [AW-1:0] S_STR   = AW'(S_STRIDE);
    localparam logic [AW-1:0] S_BLK_A = AW'(S_BLK);
    localparam logic [AW-1:0] B_BASEA = AW'(B_BASE);
    localparam logic [AW-1:0] B_ROW_A = AW'(B_ROW);
    localparam logic [AW-1:0] B_BLK_A = AW'(B_BLK);

    logic [AW-1:0] t_a;
    logic [AW-1:0] l_a;
    logic [AW-1:0] r_a;
    logic [AW-1:0] blk_a;
    logic [AW-1:0] odd_off;

    assign t_a     = AW'(t_i);
    assign l_a     = AW'(l_i);
    assign r_a     = AW'(r_i);
    assign blk_a   = AW'(blk_i);
    // Odd blocks read the second half of S while reusing A.
    assign odd_off = blk_i[0] ? S_BLK_A : '0;

    always_comb begin
        addr_hash_o = '0;
        addr_sp_o   = '0;
        unique case (state_i)
            S_LOAD_W: begin
                // Weights load bottom row first.
                addr_sp_o = blk_a * S_BLK_A
                          + (TILE_M1 - t_a) * S_STR;
            end
            S_STREAM: begin
                addr_hash_o = l_a * A_LINE + t_a * A_STR;
                if (is_as_i) begin
                    addr_sp_o = l_a * S_LINE + t_a * S_STR
                              + odd_off;
                end
            end
            S_SAVE: begin
                // Accumulator rows drain last row first.
                addr_sp_o = B_BASEA + blk_a * B_BLK_A
                          + (TILE_M1 - r_a) * B_ROW_A;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sa_tile_sequencer.sv
// Operand/result sequencer for a TILE x TILE systolic multiplier (AS/SA).
// Ports: clk, rst_n, start, mode, hash_ready, rd_data_hash, rd_data_sp,
// acc_data in; busy, done, addr_hash, addr_sp, wen_sp, wdata_sp,
// data_left, data_right, systolic_state, systolic_mode, transp_sel,
// state_o out; stall_cnt out only when SEQ_PERF_CNT_EN is defined.
module sa_tile_sequencer
    import sa_seq_pkg::*;
#(
    parameter int TILE     = DEF_TILE,
    parameter int N_ROWS   = DEF_N_ROWS,
    parameter int N_BLK    = DEF_N_BLK,
    parameter int AW       = 32,
    parameter int DW       = 64,
    parameter int A_STRIDE = DEF_A_STRIDE,
    parameter int S_STRIDE = DEF_S_STRIDE,
    parameter int S_BLK    = 4 * S_STRIDE,
    parameter int B_BASE   = DEF_B_BASE,
    parameter int B_ROW    = DEF_B_ROW,
    parameter int B_BLK    = DEF_B_BLK,
    parameter int DRAIN    = 2 * TILE - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    input  logic          hash_ready,
    input  logic [DW-1:0] rd_data_hash,
    input  logic [DW-1:0] rd_data_sp,
    input  logic [DW-1:0] acc_data,
    output logic [AW-1:0] addr_hash,
    output logic [AW-1:0] addr_sp,
    output logic          wen_sp,
    output logic [DW-1:0] wdata_sp,
    output logic [DW-1:0] data_left,
    output logic [DW-1:0] data_right,
    output logic          systolic_state,
    output logic          systolic_mode,
    output logic          transp_sel,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]   stall_cnt,
`endif
    output logic [2:0]    state_o
);

    localparam int TW  = cw(TILE);
    localparam int LW  = cw(N_ROWS / TILE);
    localparam int BW  = cw(N_BLK);
    localparam int DCW = cw(DRAIN);

    localparam logic [TW-1:0]  T_LAST = TW'(TILE - 1);
    localparam logic [LW-1:0]  L_LAST = LW'(N_ROWS / TILE - 1);
    localparam logic [BW-1:0]  B_LAST = BW'(N_BLK - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);

    seq_state_e     state_q, state_d;
    logic [TW-1:0]  t_q, t_d;
    logic [LW-1:0]  l_q, l_d;
    logic [TW-1:0]  r_q, r_d;
    logic [DCW-1:0] d_q, d_d;
    logic [BW-1:0]  blk_q, blk_d;
    logic           is_as_q, is_as_d;
    logic           transp_q, transp_d;

    logic accept;
    logic wait_exit;

    assign accept    = start && (mode == MODE_AS || mode == MODE_SA);
    // Odd blocks reuse the A data already in HASH memory.
    assign wait_exit = hash_ready || blk_q[0];

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            blk_q    <= '0;
            is_as_q  <= 1'b0;
            transp_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            l_q      <= l_d;
            r_q      <= r_d;
            d_q      <= d_d;
            blk_q    <= blk_d;
            is_as_q  <= is_as_d;
            transp_q <= transp_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // Counts only cycles actually held back by hash_ready.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && accept) begin
            stall_d = '0;
        end else if (state_q == S_WAIT_HASH && !wait_exit
                     && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        l_d      = l_q;
        r_d      = r_q;
        d_d      = d_q;
        blk_d    = blk_q;
        is_as_d  = is_as_q;
        transp_d = transp_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_as_d  = (mode == MODE_AS);
                    transp_d = 1'b1;
                    t_d      = '0;
                    l_d      = '0;
                    r_d      = '0;
                    d_d      = '0;
                    blk_d    = '0;
                    state_d  = (mode == MODE_AS) ? S_STREAM : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                t_d = t_q + TW'(1);
                if (t_q == T_LAST) begin
                    t_d     = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                t_d = t_q + TW'(1);
                if (t_q == T_LAST) begin
                    t_d      = '0;
                    transp_d = ~transp_q;
                    l_d      = l_q + LW'(1);
                    if (l_q == L_LAST) begin
                        l_d     = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                d_d = d_q + DCW'(1);
                if (d_q == D_LAST) begin
                    d_d     = '0;
                    state_d = S_SAVE;
                end
            end
            S_SAVE: begin
                r_d = r_q + TW'(1);
                if (r_q == T_LAST) begin
                    r_d = '0;
                    if (blk_q == B_LAST) begin
                        blk_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        blk_d   = blk_q + BW'(1);
                        state_d = S_WAIT_HASH;
                    end
                end
            end
            S_WAIT_HASH: begin
                if (wait_exit) begin
                    t_d     = '0;
                    l_d     = '0;
                    state_d = is_as_q ? S_STREAM : S_LOAD_W;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    sa_addr_gen #(
        .TILE     (TILE),
        .AW       (AW),
        .A_STRIDE (A_STRIDE),
        .S_STRIDE (S_STRIDE),
        .S_BLK    (S_BLK),
        .B_BASE   (B_BASE),
        .B_ROW    (B_ROW),
        .B_BLK    (B_BLK),
        .TW       (TW),
        .LW       (LW),
        .BW       (BW)
    ) u_addr (
        .state_i     (state_q),
        .is_as_i     (is_as_q),
        .t_i         (t_q),
        .l_i         (l_q),
        .r_i         (r_q),
        .blk_i       (blk_q),
        .addr_hash_o (addr_hash),
        .addr_sp_o   (addr_sp)
    );

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign wen_sp     = (state_q == S_SAVE);
    assign wdata_sp   = wen_sp ? acc_data : '0;
    assign data_left  = (state_q == S_STREAM) ? rd_data_hash : '0;
    assign data_right = (state_q == S_STREAM || state_q == S_LOAD_W)
                      ? rd_data_sp : '0;
    // DRAIN keeps the array shifting so the last partial sums flush out.
    assign systolic_state = (state_q == S_STREAM || state_q == S_DRAIN);
    assign systolic_mode  = busy && is_as_q;
    assign transp_sel     = transp_q;
    assign state_o        = state_q;

endmodule

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
- Parametrised operand/result sequencer for a TILE×TILE systolic multiplier; generalises the fixed 4×4, 1344-row Frodo controller.
- Supports AS mode (A streamed from HASH memory, S from sp-RAM) and SA mode (S preloaded as weights, A streamed).
- Handles any TILE and row count, a programmable number of output blocks, an explicit start/done handshake, and a hash_ready back-pressure stall.
- Sits between the top-level command FSM and the sp/HASH BRAMs plus the systolic array.

Parameters:
- TILE, 4, array dimension; beats per line-group; power of 2.
- N_ROWS, 1344, shared dimension; multiple of TILE.
- N_BLK, 4, output blocks per command.
- AW, 32, address width.
- DW, 64, data width.
- A_STRIDE, 21504, HASH address step between tile rows.
- S_STRIDE, 10752, sp address step between tile rows.
- S_BLK, 4*S_STRIDE, sp offset added for odd blocks.
- B_BASE, 86016, sp base address of the result matrix.
- B_ROW, 128, sp step between saved result rows.
- B_BLK, 64, sp step between result blocks.
- DRAIN, 2*TILE-1, array flush cycles after the last beat.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- mode  in  2  1=AS, 2=SA, other values ignored
- busy  out  1  high from the cycle after start through DONE
- done  out  1  one-cycle pulse in DONE
- hash_ready  in  1  HASH memory has the next block's A data
- rd_data_hash  in  DW  HASH read data
- rd_data_sp  in  DW  sp read data
- acc_data  in  DW  accumulator row being saved
- addr_hash  out  AW  HASH read address
- addr_sp  out  AW  sp read or write address
- wen_sp  out  1  sp write enable
- wdata_sp  out  DW  sp write data
- data_left  out  DW  array left operand
- data_right  out  DW  array right operand
- systolic_state  out  1  0=weight load/hold, 1=compute
- systolic_mode  out  1  1 for AS, 0 for SA
- transp_sel  out  1  ping-pong transposer select
- state_o  out  3  current state, debug

Behaviour:
- Reset: IDLE; all counters 0; every output 0 except transp_sel=1. Reset mid-operation aborts with no further writes.
- States:
  - IDLE: start with mode AS → STREAM; start with mode SA → LOAD_W; any other mode is ignored.
  - LOAD_W (SA only): exactly TILE cycles, systolic_state=0. addr_sp = blk*TILE*B_BLK... no: addr_sp = blk*S_BLK + (TILE-1-t)*S_STRIDE. data_right = rd_data_sp. Then STREAM.
  - STREAM: counters t ∈ 0..TILE-1 and l ∈ 0..N_ROWS/TILE-1. addr_hash = l*TILE*16 + t*A_STRIDE. In AS, addr_sp = l*TILE*8 + t*S_STRIDE + (blk[0] ? S_BLK : 0). systolic_state=1. On t=TILE-1 and the last l → DRAIN.
  - DRAIN: DRAIN cycles, operands forced to 0, then SAVE.
  - SAVE: TILE cycles, r = 0..TILE-1. addr_sp = B_BASE + (blk>>1)*2*B_BLK*TILE/... simplified: B_BASE + blk*B_BLK + (TILE-1-r)*B_ROW. wen_sp=1 every cycle; wdata_sp = acc_data; systolic_state=0. Then blk increments: if blk == N_BLK-1 → DONE, else → WAIT_HASH.
  - WAIT_HASH: all enables 0. Exit when hash_ready=1 or the new blk is odd (odd blocks reuse the same A). Exit goes to STREAM (AS) or LOAD_W (SA).
  - DONE: done=1 for one cycle, then IDLE.
- Operand routing:
  - data_left = rd_data_hash only in STREAM; 0 elsewhere.
  - data_right = rd_data_sp in STREAM and LOAD_W; 0 elsewhere.
  - BRAM read latency of 1 is absorbed by the array.
- transp_sel toggles whenever t wraps to 0 in STREAM; it is reset to 1 on start.
- start while busy is ignored. hash_ready outside WAIT_HASH is ignored.
- Counter widths are $clog2 of their ranges. Address arithmetic is AW-wide unsigned; overflow wraps silently.

Optional Feature:
- SEQ_PERF_CNT_EN defined: adds output stall_cnt [31:0], counting cycles spent in WAIT_HASH. It clears on start, saturates at all-ones, and holds its value after done.
- Undefined: port and logic absent; all other behaviour unchanged.

Decomposition:
- Package sa_seq_pkg holds:
  - state enum (IDLE, LOAD_W, STREAM, DRAIN, SAVE, WAIT_HASH, DONE);
  - mode constants (AS=1, SA=2);
  - default stride constants.
- Sub-module sa_addr_gen: purely combinational address computation from (state, mode, t, l, r, blk). The top holds the FSM and counters.

Test Plan (TILE=4, N_ROWS=16, N_BLK=2, DRAIN=7):
- Reset then idle → all outputs 0, transp_sel=1, state_o=IDLE.
- AS start, hash_ready tied 1 → 16 STREAM cycles, 7 DRAIN, 4 SAVE writes to B_BASE+384, +256, +128, +0. Block 1 (odd) skips the wait, writes B_BASE+64+…, then done is pulsed once; 2×(16+7+4)+2 cycles from start to done.
- AS with N_BLK=3, hash_ready low for 10 cycles after block 1 → sequencer holds in WAIT_HASH with wen_sp=0 for exactly those cycles; stall_cnt=10 when SEQ_PERF_CNT_EN is defined.
- SA start → 4 LOAD_W cycles with addr_sp = 3*S_STRIDE, 2*, 1*, 0 and systolic_state=0, then STREAM with systolic_state=1.
- start pulsed mid-STREAM, and mode=3 pulsed in IDLE → no effect either way.
- rst_n asserted during SAVE beat 2 → wen_sp drops immediately, state IDLE, no further writes.
